mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one variable-latency memory bus between the IF stage (instruction fetch)
//  and the MEM stage (byte-enabled data load/store, driven by the data-side dce/we/daddr/din).
//  Sequences each access through a request/ready handshake and holds the pipeline via
//  stall_req until the access completes. A watchdog aborts hung transfers.
//  Sits between the pipeline stages and the external memory/bus interface.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    32   data width (byte enables = DATA_W/8)
//  TIMEOUT   255  max cycles waiting for bus_ready before abort (>=2)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  flush        in   1       exception flush from CP0 (discard pending fetch)
//  if_req       in   1       fetch request, held high until if_ack
//  if_addr      in   ADDR_W  fetch address, stable while if_req
//  if_rdata     out  DATA_W  fetched word
//  if_ack       out  1       fetch complete (1-cycle pulse)
//  dm_dce       in   1       data access request, held until dm_ack
//  dm_we        in   4       byte write enables (0000 = load)
//  dm_dre       in   4       byte read enables
//  dm_addr      in   ADDR_W  data address
//  dm_wdata     in   DATA_W  store data, already lane-aligned
//  dm_rdata     out  DATA_W  load data
//  dm_ack       out  1       data access complete (1-cycle pulse)
//  bus_err      out  1       1-cycle pulse with an ack when transfer timed out
//  stall_req    out  1       pipeline stall request
//  bus_req      out  1       bus transfer valid
//  bus_addr     out  ADDR_W  registered bus address
//  bus_be       out  4       registered byte enables (we|dre of grantee; 1111 for fetch)
//  bus_we       out  1       registered write strobe (|dm_we)
//  bus_wdata    out  DATA_W  registered write data
//  bus_rdata    in   DATA_W  read data, valid with bus_ready
//  bus_ready    in   1       transfer done (1-cycle pulse)
// BEHAVIOUR
//  Reset: state IDLE; bus_req/bus_we/bus_be/bus_addr/bus_wdata=0; if_rdata/dm_rdata=0;
//   if_ack/dm_ack/bus_err=0; wdog=0; discard flag=0. Reset mid-transfer drops bus_req at once.
//  FSM: IDLE, DM_BUSY, IF_BUSY.
//   IDLE: dm_dce -> latch dm_* into bus regs, DM_BUSY; else if_req -> latch if_addr,
//    be=1111, we=0, IF_BUSY; else stay. MEM strictly beats IF (older instruction).
//   *_BUSY: bus_req=1, bus regs frozen. On bus_ready -> IDLE, ack grantee combinationally
//    in the same cycle; grantee rdata register <= bus_rdata (held until next ack of that port).
//    Writes ack without updating dm_rdata.
//  Latency: grant in cycle after request seen in IDLE; ack = bus latency + 1 minimum.
//   Next request evaluated in IDLE the cycle after ack (no back-to-back grant).
//  Watchdog: wdog counts cycles in *_BUSY, cleared on entry; when wdog==TIMEOUT-1 and no
//   bus_ready -> abort: ack grantee with bus_err=1, rdata <= 0, state IDLE.
//  stall_req = (dm_dce & ~dm_ack) | (if_req & ~if_ack); 0 in reset.
//  flush: in IF_BUSY sets discard; transfer still completes on bus; if_ack suppressed,
//   if_rdata not updated. In DM_BUSY flush ignored (MEM access committed, acked normally).
//   In IDLE flush blocks IF grant that cycle only. discard clears on return to IDLE.
//  Simultaneous bus_ready and watchdog expiry: bus_ready wins, bus_err=0.
//  bus_ready while IDLE: ignored. if_req dropped mid IF_BUSY: transfer completes, no ack.
// STRUCTURE
//  Shared package: state encoding (IDLE/DM_BUSY/IF_BUSY), BE_FULL=4'b1111, width constants.
//  Single flat module; watchdog counter inline (width $clog2(TIMEOUT+1)). No sub-modules.
// TESTING
//  1 load: dm_dce=1,dm_dre=1111,addr=0x100; ready after 3 cycles, rdata=0xDEADBEEF
//    -> bus_req 3 cycles, dm_ack pulse with ready, dm_rdata=0xDEADBEEF, stall_req low after.
//  2 contention: if_req and dm_dce (sb, we=0100, addr=0x201) same cycle -> DM granted first,
//    bus_be=0100,bus_we=1; IF granted the cycle after dm_ack.
//  3 timeout (TIMEOUT=8): never assert bus_ready -> bus_err+if_ack at 8th busy cycle,
//    if_rdata=0, state IDLE.
//  4 flush: flush during IF_BUSY, ready 2 cycles later -> no if_ack, if_rdata unchanged.
//  5 async reset mid DM_BUSY -> bus_req=0 immediately, all outputs reset values; after
//    release, pending dm_dce re-granted from IDLE.
//  6 ready and watchdog expiry same cycle -> normal ack, bus_err=0, data captured.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// State encoding, full byte-enable mask and default bus widths.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;

    localparam logic [BE_W-1:0] BE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DM_BUSY = 2'd1,
        ST_IF_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch
// and data access, with pipeline stall, flush discard and a transfer watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_dce,
    input  logic [BE_W-1:0]   dm_we,
    input  logic [BE_W-1:0]   dm_dre,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              bus_err,
    output logic              stall_req,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    arb_state_t        r_state;
    logic [WD_W-1:0]   r_wdog;
    logic              r_discard;
    logic              r_bus_req;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [BE_W-1:0]   r_bus_be;
    logic              r_bus_we;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_expire;
    logic              w_dm_done;
    logic              w_if_done;
    logic              w_if_drop;
    logic              w_if_ack;
    logic [DATA_W-1:0] w_cap_data;

    // bus_ready beats an expiring watchdog in the same cycle
    assign w_expire   = (r_state != ST_IDLE) && (r_wdog == WD_LAST) && !bus_ready;
    assign w_dm_done  = (r_state == ST_DM_BUSY) && (bus_ready || w_expire);
    assign w_if_done  = (r_state == ST_IF_BUSY) && (bus_ready || w_expire);
    assign w_if_drop  = r_discard || flush || !if_req;
    assign w_if_ack   = w_if_done && !w_if_drop;
    assign w_cap_data = bus_ready ? bus_rdata : '0;

    assign dm_ack    = w_dm_done;
    assign if_ack    = w_if_ack;
    assign bus_err   = w_expire && (w_dm_done || w_if_ack);
    assign stall_req = !rst && ((dm_dce && !w_dm_done) || (if_req && !w_if_ack));

    assign bus_req   = r_bus_req;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_we    = r_bus_we;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wdog      <= '0;
            r_discard   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_wdog    <= '0;
                    r_discard <= 1'b0;
                    // MEM holds the older instruction, so it always wins
                    if (dm_dce) begin
                        r_bus_addr  <= dm_addr;
                        r_bus_be    <= dm_we | dm_dre;
                        r_bus_we    <= |dm_we;
                        r_bus_wdata <= dm_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_DM_BUSY;
                    end else if (if_req && !flush) begin
                        r_bus_addr  <= if_addr;
                        r_bus_be    <= BE_FULL;
                        r_bus_we    <= 1'b0;
                        r_bus_wdata <= '0;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_IF_BUSY;
                    end
                end
                ST_DM_BUSY: begin
                    if (w_dm_done) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        r_wdog    <= '0;
                        if (!r_bus_we) begin
                            r_dm_rdata <= w_cap_data;
                        end
                    end else begin
                        r_wdog <= r_wdog + WD_ONE;
                    end
                end
                ST_IF_BUSY: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (w_if_done) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        r_wdog    <= '0;
                        r_discard <= 1'b0;
                        if (w_if_ack) begin
                            r_if_rdata <= w_cap_data;
                        end
                    end else begin
                        r_wdog <= r_wdog + WD_ONE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                    r_wdog    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a short watchdog (TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_dce;
    logic [3:0]  dm_we;
    logic [3:0]  dm_dre;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_err;
    logic        stall_req;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int n_cmp;
    int n_fail;

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_dce   (dm_dce),
        .dm_we    (dm_we),
        .dm_dre   (dm_dre),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .bus_err  (bus_err),
        .stall_req(stall_req),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_be   (bus_be),
        .bus_we   (bus_we),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        flush = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        dm_dce = 1'b0;
        dm_we = '0;
        dm_dre = '0;
        dm_addr = '0;
        dm_wdata = '0;
        bus_rdata = '0;
        bus_ready = 1'b0;

        // reset state
        cyc(); #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall", stall_req, 0);
        cyc(); rst = 1'b0;

        // 1: load, bus ready in 3rd busy cycle
        cyc();
        dm_dce = 1'b1; dm_dre = 4'b1111; dm_we = 4'b0000; dm_addr = 32'h100;
        #1;
        chk("t1_req_idle", bus_req, 0);
        chk("t1_stall", stall_req, 1);
        cyc(); #1;
        chk("t1_req_b1", bus_req, 1);
        chk("t1_addr", bus_addr, 32'h100);
        chk("t1_be", bus_be, 4'b1111);
        chk("t1_we", bus_we, 0);
        chk("t1_ack_b1", dm_ack, 0);
        cyc(); #1;
        chk("t1_req_b2", bus_req, 1);
        cyc();
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_req_b3", bus_req, 1);
        chk("t1_ack", dm_ack, 1);
        chk("t1_stall_ack", stall_req, 0);
        cyc();
        bus_ready = 1'b0; dm_dce = 1'b0; dm_dre = 4'b0000;
        #1;
        chk("t1_rdata", dm_rdata, 32'hDEADBEEF);
        chk("t1_req_after", bus_req, 0);
        chk("t1_ack_after", dm_ack, 0);
        chk("t1_stall_after", stall_req, 0);

        // bus_ready while idle is ignored
        cyc();
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        #1;
        chk("idle_rdy_dmack", dm_ack, 0);
        chk("idle_rdy_ifack", if_ack, 0);
        cyc(); bus_ready = 1'b0; #1;
        chk("idle_rdy_rdata", dm_rdata, 32'hDEADBEEF);
        chk("idle_rdy_req", bus_req, 0);

        // 2: contention, store byte wins over fetch
        cyc();
        if_req = 1'b1; if_addr = 32'h400;
        dm_dce = 1'b1; dm_we = 4'b0100; dm_addr = 32'h201; dm_wdata = 32'h00AA0000;
        #1;
        chk("t2_stall", stall_req, 1);
        cyc(); #1;
        chk("t2_addr", bus_addr, 32'h201);
        chk("t2_be", bus_be, 4'b0100);
        chk("t2_we", bus_we, 1);
        chk("t2_wdata", bus_wdata, 32'h00AA0000);
        bus_ready = 1'b1; bus_rdata = 32'h99999999;
        #1;
        chk("t2_dmack", dm_ack, 1);
        chk("t2_ifack", if_ack, 0);
        chk("t2_stall_if", stall_req, 1);
        cyc();
        bus_ready = 1'b0; dm_dce = 1'b0; dm_we = 4'b0000;
        #1;
        chk("t2_gap_req", bus_req, 0);
        chk("t2_store_rdata", dm_rdata, 32'hDEADBEEF);
        cyc(); #1;
        chk("t2_if_req", bus_req, 1);
        chk("t2_if_addr", bus_addr, 32'h400);
        chk("t2_if_be", bus_be, 4'b1111);
        chk("t2_if_we", bus_we, 0);
        bus_ready = 1'b1; bus_rdata = 32'h12345678;
        #1;
        chk("t2_if_ack", if_ack, 1);
        chk("t2_if_err", bus_err, 0);
        cyc(); bus_ready = 1'b0; if_req = 1'b0; #1;
        chk("t2_if_rdata", if_rdata, 32'h12345678);

        // 3: fetch timeout at 8th busy cycle
        cyc(); if_req = 1'b1; if_addr = 32'h500; #1;
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk("t3_ack", if_ack, (k == 8) ? 32'd1 : 32'd0);
            chk("t3_err", bus_err, (k == 8) ? 32'd1 : 32'd0);
        end
        cyc(); if_req = 1'b0; #1;
        chk("t3_rdata", if_rdata, 0);
        chk("t3_req", bus_req, 0);

        // 4: flush during fetch discards the result
        cyc(); if_req = 1'b1; if_addr = 32'h600; #1;
        cyc(); flush = 1'b1; #1;
        chk("t4_req", bus_req, 1);
        chk("t4_ack_fl", if_ack, 0);
        cyc(); flush = 1'b0; #1;
        cyc();
        bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        chk("t4_ack", if_ack, 0);
        chk("t4_err", bus_err, 0);
        cyc(); bus_ready = 1'b0; if_req = 1'b0; #1;
        chk("t4_rdata", if_rdata, 0);
        chk("t4_req_after", bus_req, 0);

        // flush in idle blocks the fetch grant for that cycle only
        cyc(); if_req = 1'b1; if_addr = 32'h640; flush = 1'b1; #1;
        cyc(); flush = 1'b0; #1;
        chk("fi_blocked", bus_req, 0);
        cyc(); #1;
        chk("fi_granted", bus_req, 1);
        chk("fi_addr", bus_addr, 32'h640);
        bus_ready = 1'b1; bus_rdata = 32'h11112222;
        #1;
        chk("fi_ack", if_ack, 1);
        cyc(); bus_ready = 1'b0; if_req = 1'b0; #1;
        chk("fi_rdata", if_rdata, 32'h11112222);

        // 5: async reset mid data access
        cyc();
        dm_dce = 1'b1; dm_dre = 4'b1111; dm_addr = 32'h700;
        #1;
        cyc(); #1;
        chk("t5_req_busy", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_rst", bus_req, 0);
        chk("t5_addr_rst", bus_addr, 0);
        chk("t5_be_rst", bus_be, 0);
        chk("t5_dm_rdata", dm_rdata, 0);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_stall_rst", stall_req, 0);
        cyc(); rst = 1'b0; #1;
        chk("t5_req_rel", bus_req, 0);
        chk("t5_stall_rel", stall_req, 1);
        cyc(); #1;
        chk("t5_regrant", bus_req, 1);
        chk("t5_addr", bus_addr, 32'h700);
        bus_ready = 1'b1; bus_rdata = 32'h55AA55AA;
        #1;
        chk("t5_ack", dm_ack, 1);
        cyc(); bus_ready = 1'b0; dm_dce = 1'b0; dm_dre = 4'b0000; #1;
        chk("t5_rdata", dm_rdata, 32'h55AA55AA);

        // 6: bus_ready coincides with watchdog expiry
        cyc();
        dm_dce = 1'b1; dm_dre = 4'b1111; dm_addr = 32'h800;
        #1;
        for (int k = 1; k <= 7; k++) begin
            cyc(); #1;
            chk("t6_wait_ack", dm_ack, 0);
        end
        cyc();
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        #1;
        chk("t6_ack", dm_ack, 1);
        chk("t6_err", bus_err, 0);
        cyc(); bus_ready = 1'b0; dm_dce = 1'b0; dm_dre = 4'b0000; #1;
        chk("t6_rdata", dm_rdata, 32'h0BADF00D);
        chk("t6_req", bus_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
